mem_arbiter_nch: RTL and testbench

- Parametrised N-channel burst arbiter between cache/external-storage masters and the single RAM port.
- Grants the memory port to one master for a whole transaction, which lasts until the RAM signals `mem_last`.
- Selects the winner by fixed priority or by round-robin.
- Adds a per-transaction watchdog and grant-visibility outputs that the previous three-master controller lacked.

---
 rtl/mem_arbiter_nch.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter_nch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_nch.sv
// N-channel burst arbiter that gives the single RAM port to one master per transaction.
// The winner is picked by fixed priority or round-robin, and an optional watchdog aborts stalled bursts.
module mem_arbiter_nch #(
  parameter int NUM_CH     = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_rw,
  input  logic [NUM_CH-1:0]            ch_op_size,
  input  logic [NUM_CH-1:0]            ch_finishes_op,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_write,
  output logic [NUM_CH-1:0]            ch_req_data,
  output logic [DATA_WIDTH-1:0]        ch_read,
  output logic [NUM_CH-1:0]            ch_read_valid,
  output logic [NUM_CH-1:0]            ch_last,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [NUM_CH-1:0]            ch_timeout,
  output logic                         busy,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic                         mem_enable,
  output logic                         mem_rw,
  output logic                         mem_op_size,
  output logic                         mem_finishes_op,
  output logic [DATA_WIDTH-1:0]        mem_write,
  input  logic                         mem_write_req_input,
  input  logic [DATA_WIDTH-1:0]        mem_read,
  input  logic                         mem_read_valid,
  input  logic                         mem_last
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] grant_reg, grant_next;
  logic [NUM_CH-1:0] timeout_reg, timeout_next;
  logic [NUM_CH-1:0] win_onehot;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;
  logic              found;
  logic              wd_expire;

  // Search starts at rr_ptr in round-robin mode and at channel 0 in fixed mode.
  always_comb begin
    win_onehot = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((((ARB_MODE != 0) ? int'(rr_ptr_reg) : 0) + k) % NUM_CH);
      if (!found && ch_enable[cand]) begin
        win_onehot[cand] = 1'b1;
        found            = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_reg[i]) grant_idx = IDX_W'(i);
    end
  end

  // A limit reached together with mem_last counts as a normal completion.
  assign wd_expire = (TIMEOUT > 0) && (wd_cnt_reg == WD_LIMIT) && !mem_last;

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    rr_ptr_next  = rr_ptr_reg;
    wd_cnt_next  = wd_cnt_reg;
    timeout_next = '0;
    case (state_reg)
      IDLE: begin
        wd_cnt_next = '0;
        if (|ch_enable) begin
          state_next = GRANT;
          grant_next = win_onehot;
        end
      end
      GRANT: begin
        if (mem_last || wd_expire) begin
          state_next  = IDLE;
          grant_next  = '0;
          rr_ptr_next = (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
          if (wd_expire) timeout_next = grant_reg;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      rr_ptr_reg  <= '0;
      wd_cnt_reg  <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      rr_ptr_reg  <= rr_ptr_next;
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign busy       = (state_reg == GRANT);
  assign mem_enable = busy;
  assign ch_grant   = grant_reg;
  assign ch_timeout = timeout_reg;
  assign ch_read    = busy ? mem_read : '0;

  assign mem_rw          = |(grant_reg & ch_rw);
  assign mem_op_size     = |(grant_reg & ch_op_size);
  assign mem_finishes_op = |(grant_reg & ch_finishes_op);

  // grant_reg is one-hot or zero, so an AND-OR mux selects the granted channel.
  always_comb begin
    mem_addr  = '0;
    mem_write = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_reg[i]) begin
        mem_addr  = mem_addr | ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_write = mem_write | ch_write[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_route
      assign ch_read_valid[gi] = grant_reg[gi] & mem_read_valid;
      assign ch_last[gi]       = grant_reg[gi] & mem_last;
      assign ch_req_data[gi]   = grant_reg[gi] & mem_write_req_input;
    end
  endgenerate

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Scoreboard bench: a fixed-priority 3-channel arbiter with watchdog and a round-robin 4-channel arbiter.
// Stimulus queues the expected grants and timeouts, and a negedge monitor checks them against both instances.
module tb_mem_arbiter_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          id;
    int          at;
    logic [3:0]  grant;
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
  } grec_t;

  typedef struct {
    int         id;
    int         at;
    logic [3:0] vec;
  } trec_t;

  grec_t gq[$];
  trec_t tq[$];
  int    exp_last[2][4];
  int    last_cnt[2][4];
  logic  prev_busy[2];
  logic [3:0] prev_grant[2];

  // Fixed-priority instance (id 0).
  logic        f_rst_n, f_rw_req, f_mlast, f_rvalid;
  logic [2:0]  f_en, f_rw, f_op, f_fin;
  logic [95:0] f_addr, f_wdata;
  logic [31:0] f_mread;
  logic [2:0]  f_req, f_rv, f_last, f_grant, f_tmo;
  logic [31:0] f_read, f_maddr, f_mwrite;
  logic        f_busy, f_men, f_mrw, f_mop, f_mfin;

  mem_arbiter_nch #(.NUM_CH(3), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(0), .TIMEOUT(8)) dut_fx (
    .clk(clk), .rst_n(f_rst_n),
    .ch_enable(f_en), .ch_rw(f_rw), .ch_op_size(f_op), .ch_finishes_op(f_fin),
    .ch_addr(f_addr), .ch_write(f_wdata),
    .ch_req_data(f_req), .ch_read(f_read), .ch_read_valid(f_rv), .ch_last(f_last),
    .ch_grant(f_grant), .ch_timeout(f_tmo), .busy(f_busy),
    .mem_addr(f_maddr), .mem_enable(f_men), .mem_rw(f_mrw), .mem_op_size(f_mop),
    .mem_finishes_op(f_mfin), .mem_write(f_mwrite),
    .mem_write_req_input(f_rw_req), .mem_read(f_mread), .mem_read_valid(f_rvalid), .mem_last(f_mlast)
  );

  // Round-robin instance (id 1), watchdog disabled.
  logic         r_rst_n, r_rw_req, r_mlast, r_rvalid;
  logic [3:0]   r_en, r_rw, r_op, r_fin;
  logic [127:0] r_addr, r_wdata;
  logic [31:0]  r_mread;
  logic [3:0]   r_req, r_rv, r_last, r_grant, r_tmo;
  logic [31:0]  r_read, r_maddr, r_mwrite;
  logic         r_busy, r_men, r_mrw, r_mop, r_mfin;

  mem_arbiter_nch #(.NUM_CH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32), .ARB_MODE(1), .TIMEOUT(0)) dut_rr (
    .clk(clk), .rst_n(r_rst_n),
    .ch_enable(r_en), .ch_rw(r_rw), .ch_op_size(r_op), .ch_finishes_op(r_fin),
    .ch_addr(r_addr), .ch_write(r_wdata),
    .ch_req_data(r_req), .ch_read(r_read), .ch_read_valid(r_rv), .ch_last(r_last),
    .ch_grant(r_grant), .ch_timeout(r_tmo), .busy(r_busy),
    .mem_addr(r_maddr), .mem_enable(r_men), .mem_rw(r_mrw), .mem_op_size(r_mop),
    .mem_finishes_op(r_mfin), .mem_write(r_mwrite),
    .mem_write_req_input(r_rw_req), .mem_read(r_mread), .mem_read_valid(r_rvalid), .mem_last(r_mlast)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int id, input int at, input logic [3:0] g,
                           input logic [31:0] a, input logic rw, input logic [31:0] w);
    grec_t r;
    r.id = id; r.at = at; r.grant = g; r.addr = a; r.rw = rw; r.wdata = w;
    gq.push_back(r);
  endtask

  task automatic exp_tmo(input int id, input int at, input logic [3:0] v);
    trec_t r;
    r.id = id; r.at = at; r.vec = v;
    tq.push_back(r);
  endtask

  task automatic mon(input int id, input logic [3:0] g, input logic bsy, input logic men,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input logic [31:0] mread, input logic rw, input logic ops, input logic fin,
                     input logic [3:0] req, input logic [3:0] rv, input logic [3:0] lst,
                     input logic [3:0] tmo, input logic [3:0] op_in, input logic [3:0] fin_in,
                     input logic mlast, input logic rvalid, input logic wreq);
    grec_t r;
    trec_t t;
    chk($sformatf("onehot%0d", id), 128'($onehot0(g)), 128'(1));
    chk($sformatf("busy_vs_grant%0d", id), 128'(bsy), 128'(g != 4'b0));
    chk($sformatf("mem_enable%0d", id), 128'(men), 128'(bsy));
    if (!bsy) begin
      chk($sformatf("idle_zero%0d", id), {addr, wd, rd, rw, ops, fin, req, rv, lst}, 128'(0));
    end else begin
      chk($sformatf("read_data%0d", id), 128'(rd), 128'(mread));
      chk($sformatf("strobes%0d", id), 128'({req, rv, lst}),
          128'({g & {4{wreq}}, g & {4{rvalid}}, g & {4{mlast}}}));
      chk($sformatf("op_fin%0d", id), 128'({ops, fin}), 128'({|(g & op_in), |(g & fin_in)}));
      if (prev_busy[id] && g !== prev_grant[id])
        chk($sformatf("grant_hold%0d", id), 128'(g), 128'(prev_grant[id]));
      if (!prev_busy[id]) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant%0d: got grant %b, none expected (cycle %0d)", id, g, cyc);
        end else begin
          r = gq.pop_front();
          chk("grant_id", 128'(id), 128'(r.id));
          chk("grant_cycle", 128'(cyc), 128'(r.at));
          chk("grant_vec", 128'(g), 128'(r.grant));
          chk("mem_addr", 128'(addr), 128'(r.addr));
          chk("mem_rw", 128'(rw), 128'(r.rw));
          chk("mem_write", 128'(wd), 128'(r.wdata));
        end
      end
    end
    for (int b = 0; b < 4; b++) if (lst[b]) last_cnt[id][b]++;
    if (tmo != 4'b0) begin
      if (tq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_timeout%0d: got %b, none expected (cycle %0d)", id, tmo, cyc);
      end else begin
        t = tq.pop_front();
        chk("tmo_id", 128'(id), 128'(t.id));
        chk("tmo_cycle", 128'(cyc), 128'(t.at));
        chk("tmo_vec", 128'(tmo), 128'(t.vec));
        chk("tmo_idle", 128'({bsy, g}), 128'(0));
      end
    end
    prev_busy[id]  = bsy;
    prev_grant[id] = g;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, {1'b0, f_grant}, f_busy, f_men, f_maddr, f_mwrite, f_read, f_mread, f_mrw, f_mop, f_mfin,
          {1'b0, f_req}, {1'b0, f_rv}, {1'b0, f_last}, {1'b0, f_tmo}, {1'b0, f_op}, {1'b0, f_fin},
          f_mlast, f_rvalid, f_rw_req);
      mon(1, r_grant, r_busy, r_men, r_maddr, r_mwrite, r_read, r_mread, r_mrw, r_mop, r_mfin,
          r_req, r_rv, r_last, r_tmo, r_op, r_fin, r_mlast, r_rvalid, r_rw_req);
    end
  end

  initial begin
    int c;
    for (int i = 0; i < 2; i++) begin
      prev_busy[i] = 1'b0; prev_grant[i] = 4'b0;
      for (int b = 0; b < 4; b++) begin exp_last[i][b] = 0; last_cnt[i][b] = 0; end
    end
    f_rst_n = 1'b0; f_en = '0; f_rw = '0; f_op = 3'b010; f_fin = 3'b101;
    f_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    f_wdata = {32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
    f_mread = 32'hCAFE_0001; f_rw_req = 1'b0; f_mlast = 1'b0; f_rvalid = 1'b0;
    r_rst_n = 1'b0; r_en = '0; r_rw = '0; r_op = 4'b0110; r_fin = 4'b1001;
    r_addr = {32'h0000_4400, 32'h0000_3300, 32'h0000_2200, 32'h0000_1100};
    r_wdata = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    r_mread = 32'hBEEF_0002; r_rw_req = 1'b0; r_mlast = 1'b0; r_rvalid = 1'b1;

    step(); mon_en = 1'b1;
    step(); f_rst_n = 1'b1; r_rst_n = 1'b1;

    // Fixed priority: 110 -> channel 1, then channel 2 as a write burst.
    step(); c = cyc; f_en = 3'b110; f_rvalid = 1'b1;
    exp_grant(0, c + 1, 4'b0010, 32'h2000, 1'b0, 32'h2222_0001); exp_last[0][1]++;
    step(); f_en = 3'b100;
    repeat (3) step();
    step(); f_mlast = 1'b1;
    step(); f_mlast = 1'b0; f_rvalid = 1'b0; f_rw = 3'b100; f_rw_req = 1'b1;
    exp_grant(0, c + 7, 4'b0100, 32'h3000, 1'b1, 32'hDEAD_BEEF); exp_last[0][2]++;
    step(); f_en = '0;
    step(); f_mlast = 1'b1;
    step(); f_mlast = 1'b0; f_rw_req = 1'b0; f_rw = '0;

    // Watchdog: 8 grant cycles without mem_last.
    step(); c = cyc; f_en = 3'b010;
    exp_grant(0, c + 1, 4'b0010, 32'h2000, 1'b0, 32'h2222_0001); exp_tmo(0, c + 9, 4'b0010);
    step(); f_en = '0;
    repeat (8) step();
    step();

    // mem_last on the limit cycle is a normal completion.
    step(); c = cyc; f_en = 3'b001;
    exp_grant(0, c + 1, 4'b0001, 32'h1000, 1'b0, 32'h1111_0000); exp_last[0][0]++;
    step(); f_en = '0;
    repeat (6) step();
    step(); f_mlast = 1'b1;
    step(); f_mlast = 1'b0;
    step();

    // Grant hold while the owner drops its request.
    step(); c = cyc; f_en = 3'b001;
    exp_grant(0, c + 1, 4'b0001, 32'h1000, 1'b0, 32'h1111_0000); exp_last[0][0]++;
    step();
    step(); f_en = 3'b010;
    step();
    step(); f_mlast = 1'b1;
    step(); f_mlast = 1'b0;
    exp_grant(0, c + 6, 4'b0010, 32'h2000, 1'b0, 32'h2222_0001); exp_last[0][1]++;
    step(); f_en = '0;
    step(); f_mlast = 1'b1;
    step(); f_mlast = 1'b0;

    // Reset on the edge where the watchdog would fire: no pulse.
    step(); c = cyc; f_en = 3'b001;
    exp_grant(0, c + 1, 4'b0001, 32'h1000, 1'b0, 32'h1111_0000);
    step(); f_en = '0;
    repeat (6) step();
    step(); f_rst_n = 1'b0;
    step(); f_rst_n = 1'b1;
    @(negedge clk); chk("fx_after_reset", 128'({f_busy, f_grant, f_tmo}), 128'(0));
    step(); step();

    // Round-robin with all four requesting: 0,1,2,3,0.
    step(); c = cyc; r_en = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_grant(1, c + 1 + 3 * k, 4'b0001 << (k % 4), r_addr[(k % 4) * 32 +: 32], 1'b0,
                r_wdata[(k % 4) * 32 +: 32]);
      exp_last[1][k % 4]++;
    end
    for (int k = 0; k < 5; k++) begin
      step();
      step(); r_mlast = 1'b1; if (k == 4) r_en = '0;
      step(); r_mlast = 1'b0;
    end

    // Pointer is 1: 0101 goes to channel 2.
    step(); c = cyc; r_en = 4'b0101;
    exp_grant(1, c + 1, 4'b0100, 32'h3300, 1'b0, 32'h3333_0002); exp_last[1][2]++;
    step(); r_en = '0;
    step(); r_mlast = 1'b1;
    step(); r_mlast = 1'b0;

    // Reset mid-burst on channel 3; afterwards the pointer restarts at 0.
    step(); c = cyc; r_en = 4'b1000;
    exp_grant(1, c + 1, 4'b1000, 32'h4400, 1'b0, 32'h4444_0003);
    step(); r_en = '0;
    step(); r_rst_n = 1'b0;
    step(); r_rst_n = 1'b1; r_en = 4'b1010;
    exp_grant(1, cyc + 1, 4'b0010, 32'h2200, 1'b0, 32'h2222_0001); exp_last[1][1]++;
    @(negedge clk); chk("rr_after_reset", 128'({r_busy, r_grant, r_tmo, r_last}), 128'(0));
    step(); r_en = '0;
    step(); r_mlast = 1'b1;
    step(); r_mlast = 1'b0;
    step(); step();

    chk("grant_queue_drained", 128'(gq.size()), 128'(0));
    chk("tmo_queue_drained", 128'(tq.size()), 128'(0));
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++)
        chk($sformatf("last_count%0d_%0d", i, b), 128'(last_cnt[i][b]), 128'(exp_last[i][b]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
